// File: rtl/id_operand_stage.sv
// Decode-stage operand resolution: forwarding, long-latency bypass, register
// scoreboard for outstanding long writes, and the ID/EX pipeline register.
module id_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_FWD  = 2,
  parameter int MAX_LONG = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid_i,
  input  logic [NUM_RD-1:0]                 id_re_i,
  input  logic [NUM_RD*REG_AW-1:0]          id_raddr_i,
  input  logic [NUM_RD*DATA_W-1:0]          id_imm_i,
  input  logic [NUM_RD*DATA_W-1:0]          rf_rdata_i,
  input  logic                              id_wreg_i,
  input  logic [REG_AW-1:0]                 id_wd_i,
  input  logic                              id_long_i,
  input  logic [NUM_FWD-1:0]                fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0]         fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]         fwd_wdata_i,
  input  logic [NUM_FWD-1:0]                fwd_rdy_i,
  input  logic                              lng_done_i,
  input  logic [REG_AW-1:0]                 lng_wd_i,
  input  logic [DATA_W-1:0]                 lng_wdata_i,
  input  logic                              ex_stall_i,
  input  logic                              flush_i,
  output logic                              stallreq_o,
  output logic                              ex_valid_o,
  output logic [NUM_RD*DATA_W-1:0]          ex_opnd_o,
  output logic                              ex_wreg_o,
  output logic [REG_AW-1:0]                 ex_wd_o,
  output logic                              ex_long_o,
  output logic [$clog2(MAX_LONG+1)-1:0]     sb_cnt_o,
  output logic                              sb_err_o
);

  localparam int SB_CW    = $clog2(MAX_LONG + 1);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic [NUM_RD-1:0]        hazard;
  logic [NUM_RD*DATA_W-1:0] opnd_sel;
  logic                     fwd_hit;
  logic [REG_AW-1:0]        ra;
  logic                     long_block;
  logic                     issue;
  logic                     sb_set;
  logic                     sb_clr;

  logic                     ex_valid_q, ex_valid_d;
  logic [NUM_RD*DATA_W-1:0] ex_opnd_q, ex_opnd_d;
  logic                     ex_wreg_q, ex_wreg_d;
  logic [REG_AW-1:0]        ex_wd_q, ex_wd_d;
  logic                     ex_long_q, ex_long_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [SB_CW-1:0]         sb_cnt_q, sb_cnt_d;
  logic                     sb_err_q, sb_err_d;

  // Operand priority: immediate, r0, youngest matching forward stage,
  // completing long result, scoreboard hazard, then register file.
  always_comb begin
    hazard   = '0;
    opnd_sel = '0;
    fwd_hit  = 1'b0;
    ra       = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra      = id_raddr_i[p*REG_AW +: REG_AW];
      fwd_hit = 1'b0;
      if (!id_re_i[p]) begin
        opnd_sel[p*DATA_W +: DATA_W] = id_imm_i[p*DATA_W +: DATA_W];
      end else if (ra == '0) begin
        opnd_sel[p*DATA_W +: DATA_W] = '0;
      end else begin
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!fwd_hit && fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == ra)) begin
            fwd_hit = 1'b1;
            if (fwd_rdy_i[k]) begin
              opnd_sel[p*DATA_W +: DATA_W] = fwd_wdata_i[k*DATA_W +: DATA_W];
            end else begin
              hazard[p] = 1'b1;
            end
          end
        end
        if (!fwd_hit) begin
          if (lng_done_i && (lng_wd_i == ra)) begin
            opnd_sel[p*DATA_W +: DATA_W] = lng_wdata_i;
          end else if (busy_q[ra]) begin
            hazard[p] = 1'b1;
          end else begin
            opnd_sel[p*DATA_W +: DATA_W] = rf_rdata_i[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // WAW and capacity checks deliberately ignore this cycle's completion.
  always_comb begin
    long_block = id_long_i && id_wreg_i &&
                 (busy_q[id_wd_i] || (sb_cnt_q == SB_CW'(MAX_LONG)));
    stallreq_o = id_valid_i && !flush_i && ((|hazard) || long_block);
    issue      = id_valid_i && !stallreq_o && !ex_stall_i && !flush_i;
  end

  always_comb begin
    sb_set   = issue && id_long_i && id_wreg_i && (id_wd_i != '0);
    sb_clr   = lng_done_i && busy_q[lng_wd_i];
    busy_d   = busy_q;
    if (sb_clr) begin
      busy_d[lng_wd_i] = 1'b0;
    end
    if (sb_set) begin
      busy_d[id_wd_i] = 1'b1;
    end
    sb_cnt_d = sb_cnt_q + SB_CW'(sb_set) - SB_CW'(sb_clr);
    sb_err_d = sb_err_q || (lng_done_i && !busy_q[lng_wd_i]);
  end

  // Flush beats a downstream stall; an idle or stalled ID cycle inserts a bubble.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_opnd_d  = ex_opnd_q;
    ex_wreg_d  = ex_wreg_q;
    ex_wd_d    = ex_wd_q;
    ex_long_d  = ex_long_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      ex_wreg_d  = 1'b0;
      ex_long_d  = 1'b0;
    end else if (!ex_stall_i) begin
      if (issue) begin
        ex_valid_d = 1'b1;
        ex_opnd_d  = opnd_sel;
        ex_wreg_d  = id_wreg_i;
        ex_wd_d    = id_wd_i;
        ex_long_d  = id_long_i;
      end else begin
        ex_valid_d = 1'b0;
        ex_wreg_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_opnd_q  <= '0;
      ex_wreg_q  <= 1'b0;
      ex_wd_q    <= '0;
      ex_long_q  <= 1'b0;
      busy_q     <= '0;
      sb_cnt_q   <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_opnd_q  <= ex_opnd_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_wd_q    <= ex_wd_d;
      ex_long_q  <= ex_long_d;
      busy_q     <= busy_d;
      sb_cnt_q   <= sb_cnt_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_opnd_o  = ex_opnd_q;
  assign ex_wreg_o  = ex_wreg_q;
  assign ex_wd_o    = ex_wd_q;
  assign ex_long_o  = ex_long_q;
  assign sb_cnt_o   = sb_cnt_q;
  assign sb_err_o   = sb_err_q;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the decode-stage operand logic of the in-order integer pipeline.
- Resolves NUM_RD source operands from several sources:
  - register file or immediate;
  - NUM_FWD downstream forwarding stages;
  - a long-latency unit (divider / multi-cycle MAC) result bypass.
- Tracks outstanding long-latency writes in a register scoreboard and raises a stall request on unresolved hazards.
- Registers the resolved operands into the ID/EX boundary with stall/flush handling.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register address width (2**REG_AW architectural registers)
NUM_RD, 2, source operand ports
NUM_FWD, 2, forwarding stages; index 0 = youngest (EX), highest priority
MAX_LONG, 4, max outstanding long-latency writes (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
id_valid_i  in  1  decoded instruction present
id_re_i  in  NUM_RD  per-port register-read enable
id_raddr_i  in  NUM_RD*REG_AW  per-port source register
id_imm_i  in  NUM_RD*DATA_W  per-port immediate, used when re=0
rf_rdata_i  in  NUM_RD*DATA_W  register-file read data
id_wreg_i  in  1  instruction writes a register
id_wd_i  in  REG_AW  destination register
id_long_i  in  1  destination is written by the long-latency unit
fwd_wreg_i  in  NUM_FWD  stage writes a register
fwd_wd_i  in  NUM_FWD*REG_AW  stage destination
fwd_wdata_i  in  NUM_FWD*DATA_W  stage result
fwd_rdy_i  in  NUM_FWD  stage result available (0 = load in flight)
lng_done_i  in  1  long unit completes this cycle
lng_wd_i  in  REG_AW  completing destination
lng_wdata_i  in  DATA_W  completing result
ex_stall_i  in  1  downstream cannot accept
flush_i  in  1  kill the instruction in ID and at ID/EX
stallreq_o  out  1  hazard stall request (combinational)
ex_valid_o  out  1  ID/EX holds a valid instruction
ex_opnd_o  out  NUM_RD*DATA_W  resolved operands
ex_wreg_o  out  1  registered write enable
ex_wd_o  out  REG_AW  registered destination
ex_long_o  out  1  registered long flag
sb_cnt_o  out  clog2(MAX_LONG+1)  outstanding long writes
sb_err_o  out  1  sticky: lng_done_i on a non-busy register

Behaviour:
- Reset (rst=0, async): ex_valid_o=0, ex_opnd_o=0, ex_wreg_o=0, ex_wd_o=0, ex_long_o=0, all busy bits=0, sb_cnt_o=0, sb_err_o=0.
- Per-port operand select (combinational, first match wins):
  - re=0 -> imm.
  - raddr==0 -> 0; register 0 is never forwarded and never busy.
  - Lowest-index stage k with fwd_wreg_i[k] and fwd_wd_i[k]==raddr: if fwd_rdy_i[k] use fwd_wdata_i[k], else hazard.
  - lng_done_i and lng_wd_i==raddr -> lng_wdata_i.
  - busy[raddr] -> hazard.
  - Otherwise rf_rdata_i.
- stallreq_o = id_valid_i & !flush_i & (any port hazard | (id_long_i & id_wreg_i & (busy[id_wd_i] | sb_cnt_o==MAX_LONG))).
  - The WAW and capacity checks use current-cycle state, before this cycle's completion is applied.
- issue = id_valid_i & !stallreq_o & !ex_stall_i & !flush_i.
- ID/EX register, priority flush > ex_stall_i > issue:
  - flush_i: ex_valid_o=0, ex_wreg_o=0, ex_long_o=0.
  - ex_stall_i: hold all outputs.
  - issue: load operands and controls, ex_valid_o=1.
  - Otherwise (stall or no instruction): bubble, ex_valid_o=0, ex_wreg_o=0.
  - Latency: 1 cycle from ID to ID/EX.
- Scoreboard, on each clock edge:
  - set: issue & id_long_i & id_wreg_i & id_wd_i!=0 -> busy[id_wd_i]=1.
  - clear: lng_done_i & busy[lng_wd_i] -> busy[lng_wd_i]=0.
  - lng_done_i on a non-busy register: sb_err_o=1 (sticky until reset), count unchanged.
  - sb_cnt_o += set − clear; set and clear in the same cycle leave the count unchanged.
  - Same-register set and clear in one cycle cannot occur: the busy check stalls issue.
- flush_i does not clear the scoreboard; already-issued long ops still complete.
- Reset mid-operation discards all outstanding entries.

Test Plan:
- Port0 reads r3 with fwd0 wd=3, rdy=1, data 0xAAAA0000 and fwd1 wd=3, data 0x11111111 -> ex_opnd_o[0]=0xAAAA0000 next cycle, no stall.
- fwd0 wd=4 with rdy=0 and port1 reads r4 -> stallreq_o=1, ex_valid_o=0; next cycle fwd1 rdy=1, data 0x5 -> issue, operand 0x5.
- Issue long op to r7 -> busy[7]=1, sb_cnt_o=1. Read r7 -> stall. Assert lng_done_i for r7 with data 0x1234 -> same-cycle issue with operand 0x1234; sb_cnt_o=0.
- Issue four long ops (r1–r4, MAX_LONG=4); fifth long op to r5 -> stall until one completes. lng_done_i for r9 (not busy) -> sb_err_o=1.
- ex_stall_i=1 and flush_i=1 together -> ex_valid_o=0. ex_stall_i alone -> outputs held unchanged for 3 cycles.
- Port0 raddr=0 while fwd0 wd=0, data 0xFFFFFFFF -> operand 0. Assert rst low mid-stream -> all outputs and sb_cnt_o=0 immediately, without waiting for a clock.
